// File: rtl/fgen_pkg.sv
// Shared definitions for the function-generator waveform blocks.
// Level-code width and the system clock rate are common to every generator.
package fgen_pkg;

    localparam int AMP_W  = 6;
    localparam int CLK_HZ = 50_000_000;

    typedef logic [AMP_W-1:0] amp_t;

endpackage

// File: rtl/squarewave_generator_if.sv
// Control and level-code bundle between a square-wave generator and its user.
interface squarewave_generator_if;
    import fgen_pkg::*;

    logic Enable_SW_3;
    amp_t Scale;
    amp_t Duty_Output;

    modport master (output Enable_SW_3, output Scale, input Duty_Output);
    modport slave  (input Enable_SW_3, input Scale, output Duty_Output);

endinterface

// File: rtl/half_period_timer.sv
// Counts HALF_PERIOD cycles per half and toggles the phase at terminal count.
// Disabling parks the counter at zero with the phase set to the high half.
module half_period_timer
    import fgen_pkg::*;
#(
    parameter int HALF_PERIOD = 25000,
    parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic cnt_zero_o,
    output logic terminal_o,
    output logic phase_o
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Next-state for the half-period counter and phase
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = 1'b1;
        end else if (cnt_q == TERM_CNT) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt_zero_o = (cnt_q == {CNT_W{1'b0}});
    assign terminal_o = (cnt_q == TERM_CNT);
    assign phase_o    = phase_q;

endmodule

// File: rtl/squarewave_generator.sv
// 50 % duty square wave between 0 and the amplitude latched at each half start.
// The amplitude is resampled only when a half-period begins.
module squarewave_generator #(
    parameter int CLK_HZ      = fgen_pkg::CLK_HZ,
    parameter int WAVE_HZ     = 1000,
    parameter int HALF_PERIOD = CLK_HZ / (2 * WAVE_HZ),
    parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    squarewave_generator_if.slave  sw_if
);
    import fgen_pkg::*;

    amp_t scale_q, scale_d;
    amp_t duty_q, duty_d;
    amp_t level_s;
    logic cnt_zero_s, terminal_s, phase_s;

    half_period_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk        (sysclk),
        .rst_n      (rst_n),
        .en_i       (sw_if.Enable_SW_3),
        .cnt_zero_o (cnt_zero_s),
        .terminal_o (terminal_s),
        .phase_o    (phase_s)
    );

    // Amplitude capture at half start; the terminal cycle keeps the old level
    always_comb begin
        level_s = scale_q;
        scale_d = scale_q;
        duty_d  = {AMP_W{1'b0}};
        if (sw_if.Enable_SW_3) begin
            case ({cnt_zero_s, terminal_s})
                2'b10: begin
                    level_s = sw_if.Scale;
                    scale_d = sw_if.Scale;
                end
                2'b01: begin
                    level_s = scale_q;
                    scale_d = scale_q;
                end
                default: begin
                    level_s = scale_q;
                    scale_d = scale_q;
                end
            endcase
            duty_d = phase_s ? level_s : {AMP_W{1'b0}};
        end else begin
            scale_d = scale_q;
            duty_d  = {AMP_W{1'b0}};
        end
    end

    // Latched amplitude and output level registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q <= {AMP_W{1'b0}};
            duty_q  <= {AMP_W{1'b0}};
        end else begin
            scale_q <= scale_d;
            duty_q  <= duty_d;
        end
    end

    assign sw_if.Duty_Output = duty_q;

endmodule

// File: tb/tb_squarewave_generator.sv
// Self-checking bench: three generators (half periods 25, 2 and the default)
// compared cycle by cycle against an arithmetic model of the waveform.
module tb_squarewave_generator;
    import fgen_pkg::*;

    localparam int NDUT = 3;
    localparam int HP_TAB [NDUT] = '{25, 2, 25000};

    logic sysclk = 1'b0;
    logic rst_n;
    logic en    [NDUT];
    amp_t scale [NDUT];
    amp_t dout  [NDUT];
    amp_t mexp  [NDUT];

    int checks   = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int HP = HP_TAB[g];

        squarewave_generator_if ifc ();
        assign ifc.Enable_SW_3 = en[g];
        assign ifc.Scale       = scale[g];
        assign dout[g]         = ifc.Duty_Output;

        if (g == 2) begin : g_def
            squarewave_generator dut (.sysclk(sysclk), .rst_n(rst_n), .sw_if(ifc));
        end else begin : g_ovr
            squarewave_generator #(.HALF_PERIOD(HP)) dut (.sysclk(sysclk), .rst_n(rst_n), .sw_if(ifc));
        end

        // Model: k counts enabled cycles; half index = k / HP, even halves are high
        int   k;
        amp_t amp;
        amp_t lvl;
        always @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                k   <= 0;
                amp <= 6'd0;
                lvl <= 6'd0;
            end else if (!en[g]) begin
                k   <= 0;
                lvl <= 6'd0;
            end else begin
                k <= k + 1;
                if (k % HP == 0) begin
                    amp <= scale[g];
                    lvl <= ((k / HP) % 2 == 0) ? scale[g] : 6'd0;
                end else begin
                    lvl <= ((k / HP) % 2 == 0) ? amp : 6'd0;
                end
            end
        end
        assign mexp[g] = lvl;
    end

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic restart(input int d, input amp_t s);
        en[d] = 1'b0;
        tick();
        en[d]    = 1'b1;
        scale[d] = s;
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            en[d]    = 1'b1;
            scale[d] = 6'd12;
        end
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (dout[d] !== 6'd0) begin
                failures++;
                $display("FAIL reset_async d%0d got=%0d exp=0", d, dout[d]);
            end
        end
        @(negedge sysclk);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (dout[d] !== 6'd0) begin
                    failures++;
                    $display("FAIL reset_hold d%0d got=%0d exp=0", d, dout[d]);
                end
            end
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (dout[d] !== 6'd12) begin
                failures++;
                $display("FAIL reset_first_edge d%0d got=%0d exp=12", d, dout[d]);
            end
        end
    endtask

    task automatic test_default_run();
        int high_cnt;
        int fall_cyc;
        int rise_cyc;
        amp_t prev;
        high_cnt = (dout[2] == 6'd12) ? 1 : 0;
        fall_cyc = 0;
        rise_cyc = 0;
        prev     = dout[2];
        for (int c = 2; c <= 50005; c++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (dout[d] !== mexp[d]) begin
                    failures++;
                    $display("FAIL default_model d%0d cyc=%0d got=%0d exp=%0d", d, c, dout[d], mexp[d]);
                end
            end
            if (dout[2] == 6'd12) high_cnt++;
            if (prev == 6'd12 && dout[2] == 6'd0 && fall_cyc == 0) fall_cyc = c;
            if (prev == 6'd0 && dout[2] == 6'd12 && rise_cyc == 0) rise_cyc = c;
            prev = dout[2];
        end
        checks++;
        if (high_cnt != 25005) begin
            failures++;
            $display("FAIL default_high_count got=%0d exp=25005", high_cnt);
        end
        checks++;
        if (fall_cyc != 25001) begin
            failures++;
            $display("FAIL default_fall_cycle got=%0d exp=25001", fall_cyc);
        end
        checks++;
        if (rise_cyc != 50001) begin
            failures++;
            $display("FAIL default_rise_cycle got=%0d exp=50001", rise_cyc);
        end
        en[2] = 1'b0;
    endtask

    task automatic test_scale_change();
        amp_t want;
        restart(0, 6'd12);
        for (int c = 1; c <= 80; c++) begin
            if (c == 11) scale[0] = 6'd40;
            tick();
            want = (c <= 25) ? 6'd12 : (c <= 50) ? 6'd0 : (c <= 75) ? 6'd40 : 6'd0;
            checks++;
            if (dout[0] !== want || mexp[0] !== want) begin
                failures++;
                $display("FAIL scale_change cyc=%0d got=%0d model=%0d exp=%0d", c, dout[0], mexp[0], want);
            end
        end
    endtask

    task automatic test_enable_drop();
        restart(0, 6'd40);
        for (int c = 1; c <= 30; c++) tick();
        en[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (dout[0] !== 6'd0) begin
                failures++;
                $display("FAIL enable_drop cyc=%0d got=%0d exp=0", c, dout[0]);
            end
        end
        en[0]    = 1'b1;
        scale[0] = 6'd33;
        for (int c = 1; c <= 26; c++) begin
            tick();
            checks++;
            if (dout[0] !== ((c <= 25) ? 6'd33 : 6'd0)) begin
                failures++;
                $display("FAIL reenable cyc=%0d got=%0d exp=%0d", c, dout[0], (c <= 25) ? 33 : 0);
            end
        end
    endtask

    task automatic test_terminal_change();
        amp_t want;
        restart(0, 6'd20);
        for (int c = 1; c <= 51; c++) begin
            if (c == 25) scale[0] = 6'd50;
            tick();
            want = (c <= 25) ? 6'd20 : (c <= 50) ? 6'd0 : 6'd50;
            checks++;
            if (dout[0] !== want) begin
                failures++;
                $display("FAIL terminal_change cyc=%0d got=%0d exp=%0d", c, dout[0], want);
            end
        end
    endtask

    task automatic test_extremes();
        amp_t want0;
        amp_t want1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        tick();
        en[0] = 1'b1; scale[0] = 6'd63;
        en[1] = 1'b1; scale[1] = 6'd63;
        for (int c = 1; c <= 60; c++) begin
            tick();
            want0 = (((c - 1) / 25) % 2 == 0) ? 6'd63 : 6'd0;
            want1 = (((c - 1) / 2) % 2 == 0) ? 6'd63 : 6'd0;
            checks++;
            if (dout[0] !== want0) begin
                failures++;
                $display("FAIL extreme_63_hp25 cyc=%0d got=%0d exp=%0d", c, dout[0], want0);
            end
            checks++;
            if (dout[1] !== want1) begin
                failures++;
                $display("FAIL extreme_63_hp2 cyc=%0d got=%0d exp=%0d", c, dout[1], want1);
            end
        end
        restart(0, 6'd0);
        for (int c = 1; c <= 60; c++) begin
            tick();
            checks++;
            if (dout[0] !== 6'd0) begin
                failures++;
                $display("FAIL extreme_zero cyc=%0d got=%0d exp=0", c, dout[0]);
            end
        end
    endtask

    task automatic test_reset_mid_low();
        restart(0, 6'd17);
        for (int c = 1; c <= 30; c++) tick();
        checks++;
        if (dout[0] !== 6'd0) begin
            failures++;
            $display("FAIL mid_low_before got=%0d exp=0", dout[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout[0] !== 6'd0) begin
            failures++;
            $display("FAIL mid_low_async got=%0d exp=0", dout[0]);
        end
        @(negedge sysclk);
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            checks++;
            if (dout[0] !== ((c <= 25) ? 6'd17 : 6'd0)) begin
                failures++;
                $display("FAIL mid_low_restart cyc=%0d got=%0d exp=%0d", c, dout[0], (c <= 25) ? 17 : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 7) == 0) scale[d] = amp_t'($urandom_range(0, 63));
                if ($urandom_range(0, 59) == 0) en[d] = ~en[d];
            end
            tick();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (dout[d] !== mexp[d]) begin
                    failures++;
                    $display("FAIL random_model d%0d cyc=%0d got=%0d exp=%0d", d, c, dout[d], mexp[d]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            en[d]    = 1'b0;
            scale[d] = 6'd0;
        end
        @(negedge sysclk);
        test_reset();
        test_default_run();
        test_scale_change();
        test_enable_drop();
        test_terminal_change();
        test_extremes();
        test_reset_mid_low();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/squarewave_generator.md
# squarewave_generator

- Produces a fixed-frequency, 50 % duty square wave whose high level is the 6-bit `Scale` input and whose low level is 0.
- The 6-bit `Duty_Output` is a level code for a downstream PWM/DAC stage in the function-generator datapath.
- The waveform is selected by switch 3 (`Enable_SW_3`).
- Everything runs in the single `sysclk` domain.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: `sysclk` frequency.
- `WAVE_HZ`, default 1000: output square-wave frequency.
- `HALF_PERIOD`, default `CLK_HZ/(2*WAVE_HZ)` = 25000: cycles per half-period. Must be ≥ 2.
- `CNT_W`, default `$clog2(HALF_PERIOD)` = 15: counter width.

Ports:
- `sysclk`, input, 1: system clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `Enable_SW_3`, input, 1: 1 = generate the waveform; 0 = hold the output at 0 and restart the waveform.
- `Scale`, input, 6: amplitude (high-level code), unsigned 0–63.
- `Duty_Output`, output, 6: registered level code. Equals the latched `Scale` in the high half and 0 in the low half.

## Operation
State registers:
- `cnt`: `CNT_W` bits.
- `phase`: 1 bit; 1 = high half.
- `scale_q`: 6 bits.
- `Duty_Output`: 6 bits.

On each rising `sysclk`:
- **Disabled** (`Enable_SW_3` = 0):
  - `cnt` <= 0, `phase` <= 1, `Duty_Output` <= 0.
  - `scale_q` is unchanged.
- **Enabled, `cnt` == 0** (start of a half-period):
  - `scale_q` <= `Scale`.
  - `Duty_Output` <= `phase` ? `Scale` : 0.
  - `cnt` <= 1.
- **Enabled, 0 < `cnt` < `HALF_PERIOD`-1**:
  - `Duty_Output` <= `phase` ? `scale_q` : 0.
  - `cnt` <= `cnt`+1.
- **Enabled, `cnt` == `HALF_PERIOD`-1**:
  - `Duty_Output` <= `phase` ? `scale_q` : 0.
  - `cnt` <= 0, `phase` <= ~`phase`.

Consequences:
- `Scale` is sampled exactly once per half-period, so a mid-half change never alters the level within a half.
- A new `Scale` value shows on the next high half (or on the current half if it arrives at its first cycle).
- `Scale` = 0 gives a constant 0 output.
- No arithmetic beyond the counter increment. The counter never exceeds `HALF_PERIOD`-1 and wraps to 0 at terminal count.

## Timing
- **Reset** (`rst_n` low, asynchronous): `cnt` = 0, `phase` = 1, `scale_q` = 0, `Duty_Output` = 0. Release takes effect on the next `sysclk` edge.
- **Start-up latency:** on the first enabled edge after reset or after enable rises, `Duty_Output` = `Scale`, i.e. one-cycle registered latency.
- **Waveform:** exactly `HALF_PERIOD` cycles high, then exactly `HALF_PERIOD` cycles low, repeating. Period = 2·`HALF_PERIOD` cycles (1 ms at the defaults).
- **Enable drop:** `Duty_Output` = 0 on the next edge. Re-enable always restarts with a full high half.
- **Reset mid-operation:** immediate return to the reset state. No partial half-period is preserved.
- **Simultaneous** `Scale` change and terminal count: the old `scale_q` holds through the terminal cycle; the new `Scale` is taken on the following `cnt` == 0 cycle.

## Structure
- Shared package `fgen_pkg`: `AMP_W` = 6 (level-code width) and `CLK_HZ` = 50_000_000, both used by all waveform generators.
- Sub-module `half_period_timer`:
  - Parameter `HALF_PERIOD`.
  - Inputs: clock, `rst_n`, enable.
  - Outputs: `cnt_zero` and `terminal` strobes, plus a `phase` toggle.
- The top level holds `scale_q` and the output register.

## Test plan
- **Reset:** `rst_n` = 0 with `Scale` = 12, `Enable_SW_3` = 1 -> `Duty_Output` = 0 asynchronously. After release, the first edge gives 12.
- **Default run:** `Scale` = 12, enable = 1 for 5 ms -> output is 12 for 25000 cycles, then 0 for 25000 cycles. Exactly 5 full periods; edges occur at cycles 25000·k.
- **Scale change:** `Scale` goes 12→40 at cycle 10000 of a high half -> the level stays 12 until that half ends, the low half is 0, and the next high half is 40.
- **Enable drop:** `Enable_SW_3` = 0 at cycle 30000 -> output 0 from the next edge and held there. Re-enable -> 25000 cycles at the current `Scale`.
- **Extremes:** `Scale` = 63 -> alternates 63/0. `Scale` = 0 -> constant 0. `HALF_PERIOD` = 2 override -> pattern 63,63,0,0 repeating.
- **Reset mid-low-half** -> output 0. After release, a full high half of 25000 cycles.
